// File: rtl/ui_cond_pkg.sv
// Shared constants and helpers for the ui_in input conditioning stage.
//   UI_WIDTH            default number of conditioned input bits
//   UI_SYNC_STAGES      default synchroniser depth
//   UI_DEBOUNCE_CYCLES  default number of consecutive mismatch cycles before acceptance
//   cnt_width()         debounce counter width for a given debounce length
package ui_cond_pkg;

  localparam int unsigned UI_WIDTH           = 8;
  localparam int unsigned UI_SYNC_STAGES     = 2;
  localparam int unsigned UI_DEBOUNCE_CYCLES = 16;

  // Counter must hold 0..cycles-1; sized as clog2(cycles+1), never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = int'($clog2(cycles + 1));
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit input conditioner: synchroniser chain, debounce counter,
// stable level register and registered rise/fall strobes.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   ena         debounce count enable (synchroniser always runs)
//   raw         asynchronous input pin
//   level       debounced stable level (registered)
//   rise, fall  one-cycle strobes, high in the first cycle level shows its new value
//   edge_c      combinational next-cycle strobe (rise|fall), for a registered OR upstream
module debounce_bit
  import ui_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = UI_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = UI_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic edge_c
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned LAST  = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

  // Reject illegal configurations at elaboration.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_bit: SYNC_STAGES must be 2 or more");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("debounce_bit: DEBOUNCE_CYCLES must be 1 or more");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   fall_q;
  logic                   rise_c;
  logic                   fall_c;

  // Synchroniser: raw enters at bit 0, sync_q is the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Debounce next-state: count consecutive mismatches, accept on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    if (ena) begin
      if (sync_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        level_d = sync_q;
        rise_c  = sync_q;
        fall_c  = ~sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state and strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_c;
      fall_q  <= fall_c;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign edge_c = rise_c | fall_c;

endmodule

// File: rtl/ui_in_conditioner.sv
// Input conditioning stage in front of the chip core: per-bit synchronise,
// debounce, stable level and rise/fall strobes for the ui_in pins.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   ena         debounce count enable
//   raw_in      asynchronous input pins
//   level_out   debounced stable levels
//   rise_out    one-cycle 0->1 strobes of level_out
//   fall_out    one-cycle 1->0 strobes of level_out
//   any_edge    OR of all strobes, registered in the same cycle as them
module ui_in_conditioner
  import ui_cond_pkg::*;
#(
  parameter int unsigned WIDTH           = UI_WIDTH,
  parameter int unsigned SYNC_STAGES     = UI_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = UI_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             any_edge
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("ui_in_conditioner: WIDTH must be 1 or more");
    end
  endgenerate

  logic [WIDTH-1:0] edge_c;
  logic             any_edge_q;

  // One independent conditioner per input bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .raw   (raw_in[i]),
      .level (level_out[i]),
      .rise  (rise_out[i]),
      .fall  (fall_out[i]),
      .edge_c(edge_c[i])
    );
  end

  // OR the next-cycle strobes so any_edge lands in the same cycle as rise/fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |edge_c;
    end
  end

  assign any_edge = any_edge_q;

endmodule

// File: tb/tb_ui_in_conditioner.sv
// Self-checking bench for ui_in_conditioner: directed scenarios plus random
// stimulus, compared every cycle against a behavioural mismatch-run model.
module tb_ui_in_conditioner;
  import ui_cond_pkg::*;

  localparam int unsigned W  = UI_WIDTH;
  localparam int unsigned S  = UI_SYNC_STAGES;
  localparam int unsigned D  = UI_DEBOUNCE_CYCLES;
  localparam logic        RL = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] raw;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_out;
  logic [W-1:0] fall_out;
  logic         any_edge;

  always #5 clk = ~clk;

  ui_in_conditioner #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw),
    .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out),
    .any_edge(any_edge)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: pin samples pass through an S-deep delay line; a bit's
  // level flips once the delayed sample has disagreed with it for D enabled edges.
  logic [W-1:0]  dl[$];
  int unsigned   run[W];
  logic [W-1:0]  m_level, m_rise, m_fall;
  logic          m_any;

  task automatic model_edge();
    logic [W-1:0] s;
    if (!rst_n) begin
      dl.delete();
      for (int k = 0; k < int'(S); k++) dl.push_back({W{RL}});
      for (int i = 0; i < int'(W); i++) run[i] = 0;
      m_level = {W{RL}};
      m_rise  = '0;
      m_fall  = '0;
      m_any   = 1'b0;
    end else begin
      s      = dl[S-1];
      m_rise = '0;
      m_fall = '0;
      if (ena) begin
        for (int i = 0; i < int'(W); i++) begin
          if (s[i] == m_level[i]) run[i] = 0;
          else begin
            run[i]++;
            if (run[i] == D) begin
              m_level[i] = s[i];
              run[i]     = 0;
              if (s[i]) m_rise[i] = 1'b1;
              else      m_fall[i] = 1'b1;
            end
          end
        end
      end
      m_any = |(m_rise | m_fall);
      void'(dl.pop_back());
      dl.push_front(raw);
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare outputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", 32'(level_out), 32'(m_level));
    check("rise",  32'(rise_out),  32'(m_rise));
    check("fall",  32'(fall_out),  32'(m_fall));
    check("any",   32'(any_edge),  32'(m_any));
  endtask

  task automatic wait_rise(input logic [W-1:0] mask, input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      step();
      if ((rise_out & mask) != '0) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int fcnt;
    int lat;
    rst_n = 1'b0;
    ena   = 1'b1;
    raw   = 8'hFF;
    for (int i = 0; i < int'(W); i++) run[i] = 0;
    m_level = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;

    // Reset held with all pins high, then release.
    repeat (3) step();
    check("reset_level", 32'(level_out), 32'h00);
    rst_n = 1'b1;
    wait_rise(8'hFF, 40, n);
    check("release_latency", 32'(n), 32'd18);
    check("release_rise", 32'(rise_out), 32'hFF);
    check("release_level", 32'(level_out), 32'hFF);
    check("release_any", 32'(any_edge), 32'd1);
    step();
    check("release_rise_once", 32'(rise_out), 32'h00);
    raw = 8'h00;
    repeat (30) step();

    // Clean rise on bit 3.
    raw[3] = 1'b1;
    wait_rise(8'h08, 40, n);
    check("bit3_latency", 32'(n), 32'd18);
    check("bit3_rise", 32'(rise_out), 32'h08);
    check("bit3_fall", 32'(fall_out), 32'h00);
    repeat (5) step();

    // Short glitch on bit 0 is rejected.
    raw[0] = 1'b1;
    repeat (10) step();
    raw[0] = 1'b0;
    cnt = 0;
    repeat (40) begin
      step();
      if ((rise_out | fall_out) != '0) cnt++;
    end
    check("glitch10_strobes", 32'(cnt), 32'd0);
    check("glitch10_level", 32'(level_out), 32'h08);

    // Glitch lasting exactly D cycles is accepted.
    raw[0] = 1'b1;
    cnt = 0;
    repeat (16) begin
      step();
      if (rise_out[0]) cnt++;
    end
    raw[0] = 1'b0;
    repeat (40) begin
      step();
      if (rise_out[0]) cnt++;
    end
    check("glitch16_rises", 32'(cnt), 32'd1);
    repeat (10) step();

    // Bounce on bit 5, then steady high.
    cnt = 0;
    for (int seg = 0; seg < 4; seg++) begin
      raw[5] = (seg % 2 == 0);
      repeat (3) begin
        step();
        if (rise_out[5]) cnt++;
      end
    end
    raw[5] = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (rise_out[5]) begin
        cnt++;
        if (lat < 0) lat = c;
      end
    end
    check("bounce_latency", 32'(lat), 32'd18);
    check("bounce_pulses", 32'(cnt), 32'd1);

    // Freeze the counter mid-debounce on bit 1.
    raw[1] = 1'b1;
    repeat (10) step();
    ena = 1'b0;
    cnt = 0;
    repeat (20) begin
      step();
      if (rise_out[1] || level_out[1]) cnt++;
    end
    check("ena_freeze", 32'(cnt), 32'd0);
    ena = 1'b1;
    wait_rise(8'h02, 40, n);
    check("ena_resume_latency", 32'(n), 32'd8);

    // Reset mid-debounce on bit 7 restarts the full latency.
    raw[7] = 1'b1;
    repeat (14) step();
    rst_n = 1'b0;
    step();
    check("midreset_level", 32'(level_out), 32'h00);
    rst_n = 1'b1;
    fcnt = 0;
    lat  = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (fall_out != '0) fcnt++;
      if (rise_out[7]) begin
        lat = c;
        break;
      end
    end
    check("midreset_latency", 32'(lat), 32'd18);
    check("midreset_rise", 32'(rise_out), 32'(raw));
    check("midreset_falls", 32'(fcnt), 32'd0);
    repeat (5) step();

    // Random pins, enable and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < int'(W); i++)
        if ($urandom_range(0, 29) == 0) raw[i] = ~raw[i];
      ena   = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
